// File: rtl/pconv_sched.sv
// ----------------------------------------------------------------------------
// pconv_sched
//   Sequencer for one pointwise (1x1) convolution layer built on pconv_unit.
//   On start it walks the output channels. For each channel it loads the
//   packed weights, bias and shift once, streams every input pixel (one per
//   cycle) into the unit, and writes each 8-bit result to the output buffer
//   in channel-major order.
//
// Build option:
//   PCONV_SCHED_PERF_EN  adds cycle_cnt (busy cycles of the last layer) and
//                        stall_cnt (DRAIN cycles of the last layer).
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start / busy / done / err   layer control and status (err is sticky)
//   pix_rd, pix_addr, pix_din   pixel RAM, 1-cycle read latency
//   par_rd, par_addr            parameter RAM, indexed by output channel
//   w_din, b_din, s_din         weights / bias / shift, 1-cycle read latency
//   unit_*                      to/from pconv_unit
//   out_we, out_addr, out_data  output RAM write port
// ----------------------------------------------------------------------------
module pconv_sched #(
  parameter int N              = 16,
  parameter int INPUT_CHANNEL  = 3,
  parameter int OUTPUT_CHANNEL = 8,
  parameter int FMAP_SIZE      = 28,
  parameter int UNIT_LAT       = 1
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             start,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             err,
`ifdef PCONV_SCHED_PERF_EN
  output logic [31:0]                                      cycle_cnt,
  output logic [31:0]                                      stall_cnt,
`endif
  output logic                                             pix_rd,
  output logic [$clog2(FMAP_SIZE*FMAP_SIZE)-1:0]           pix_addr,
  input  logic [INPUT_CHANNEL*N-1:0]                       pix_din,
  output logic                                             par_rd,
  output logic [$clog2(OUTPUT_CHANNEL)-1:0]                par_addr,
  input  logic [INPUT_CHANNEL*N-1:0]                       w_din,
  input  logic [31:0]                                      b_din,
  input  logic [4:0]                                       s_din,
  output logic                                             unit_vld,
  output logic [INPUT_CHANNEL*N-1:0]                       unit_input,
  output logic [INPUT_CHANNEL*N-1:0]                       unit_weight,
  output logic [31:0]                                      unit_bias,
  output logic [4:0]                                       unit_shift,
  input  logic [N-1:0]                                     unit_dout,
  input  logic                                             unit_dout_vld,
  output logic                                             out_we,
  output logic [$clog2(OUTPUT_CHANNEL*FMAP_SIZE*FMAP_SIZE)-1:0] out_addr,
  output logic [7:0]                                       out_data
);

  localparam int PIX = FMAP_SIZE * FMAP_SIZE;
  localparam int PW  = $clog2(PIX);
  localparam int CW  = $clog2(OUTPUT_CHANNEL);
  localparam int AW  = $clog2(OUTPUT_CHANNEL * PIX);
  localparam int RW  = $clog2(PIX + 1);
  localparam int OW  = $clog2(UNIT_LAT + 2) + 1;
  localparam int DW  = INPUT_CHANNEL * N;

  localparam logic [PW-1:0] P_LAST = PW'(PIX - 1);
  localparam logic [CW-1:0] C_LAST = CW'(OUTPUT_CHANNEL - 1);
  localparam logic [RW-1:0] R_FULL = RW'(PIX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_LATCH = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_r;
  logic            busy_r;
  logic            done_r;
  logic            err_r;
  logic            pix_rd_r;
  logic [PW-1:0]   pix_addr_r;
  logic            par_rd_r;
  logic [CW-1:0]   par_addr_r;
  logic            unit_vld_r;
  logic [DW-1:0]   weight_r;
  logic [31:0]     bias_r;
  logic [4:0]      shift_r;
  logic [AW-1:0]   out_addr_r;
  logic [RW-1:0]   returned_r;
  logic [OW-1:0]   outstanding_r;

  logic            start_ok_s;
  logic            result_ok_s;
  logic            wr_s;
  logic            bad_s;
  logic [RW-1:0]   returned_nxt_s;
  logic            drain_done_s;
  logic            unused_s;

  assign start_ok_s     = (state_r == S_IDLE) & start;
  // A result is legal only if an issue is outstanding (or issued this cycle,
  // which matters for a zero-latency unit).
  assign result_ok_s    = (outstanding_r != {OW{1'b0}}) | unit_vld_r;
  assign wr_s           = unit_dout_vld & busy_r & result_ok_s;
  assign bad_s          = unit_dout_vld & ~wr_s;
  assign returned_nxt_s = returned_r + RW'(wr_s);
  // Counting the write of this cycle lets DRAIN end on the last return.
  assign drain_done_s   = (returned_nxt_s == R_FULL);
  assign unused_s       = &{1'b0, unit_dout[N-1:8]};

  // Layer FSM with its registered control outputs and parameter hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pix_rd_r   <= 1'b0;
      pix_addr_r <= {PW{1'b0}};
      par_rd_r   <= 1'b0;
      par_addr_r <= {CW{1'b0}};
      weight_r   <= {DW{1'b0}};
      bias_r     <= 32'd0;
      shift_r    <= 5'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r    <= S_LOAD;
            busy_r     <= 1'b1;
            par_rd_r   <= 1'b1;
            par_addr_r <= {CW{1'b0}};
            pix_addr_r <= {PW{1'b0}};
          end
        end
        S_LOAD: begin
          par_rd_r <= 1'b0;
          state_r  <= S_LATCH;
        end
        S_LATCH: begin
          weight_r   <= w_din;
          bias_r     <= b_din;
          shift_r    <= s_din;
          pix_rd_r   <= 1'b1;
          pix_addr_r <= {PW{1'b0}};
          state_r    <= S_RUN;
        end
        S_RUN: begin
          if (pix_addr_r == P_LAST) begin
            pix_rd_r   <= 1'b0;
            pix_addr_r <= {PW{1'b0}};
            state_r    <= S_DRAIN;
          end else begin
            pix_addr_r <= pix_addr_r + 1'b1;
          end
        end
        S_DRAIN: begin
          // Bias/shift are applied at the unit output, so the next channel's
          // parameters may only be fetched once every result is back.
          if (drain_done_s) begin
            if (par_addr_r != C_LAST) begin
              par_addr_r <= par_addr_r + 1'b1;
              par_rd_r   <= 1'b1;
              state_r    <= S_LOAD;
            end else begin
              done_r     <= 1'b1;
              state_r    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          par_addr_r <= {CW{1'b0}};
          state_r    <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
          pix_rd_r <= 1'b0;
          par_rd_r <= 1'b0;
        end
      endcase
    end
  end

  // Issue valid follows the pixel read by the RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_vld_r <= 1'b0;
    end else begin
      unit_vld_r <= pix_rd_r;
    end
  end

  // Result bookkeeping: per-channel return count, in-flight count, write address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      returned_r    <= {RW{1'b0}};
      outstanding_r <= {OW{1'b0}};
      out_addr_r    <= {AW{1'b0}};
    end else begin
      if (state_r == S_LOAD) begin
        returned_r <= {RW{1'b0}};
      end else if (wr_s) begin
        returned_r <= returned_nxt_s;
      end else begin
        returned_r <= returned_r;
      end

      if (start_ok_s) begin
        outstanding_r <= {OW{1'b0}};
      end else if (unit_vld_r & ~wr_s) begin
        outstanding_r <= outstanding_r + 1'b1;
      end else if (~unit_vld_r & wr_s) begin
        outstanding_r <= outstanding_r - 1'b1;
      end else begin
        outstanding_r <= outstanding_r;
      end

      if (start_ok_s) begin
        out_addr_r <= {AW{1'b0}};
      end else if (wr_s) begin
        out_addr_r <= out_addr_r + 1'b1;
      end else begin
        out_addr_r <= out_addr_r;
      end
    end
  end

  // Sticky flag for a unit result nobody asked for; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (bad_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

`ifdef PCONV_SCHED_PERF_EN
  logic [31:0] cycle_cnt_r;
  logic [31:0] stall_cnt_r;

  // Busy-cycle and drain-cycle counters, restarted by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else if (start_ok_s) begin
      cycle_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      cycle_cnt_r <= busy_r ? (cycle_cnt_r + 32'd1) : cycle_cnt_r;
      stall_cnt_r <= (state_r == S_DRAIN) ? (stall_cnt_r + 32'd1) : stall_cnt_r;
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign stall_cnt = stall_cnt_r;
`endif

  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign pix_rd      = pix_rd_r;
  assign pix_addr    = pix_addr_r;
  assign par_rd      = par_rd_r;
  assign par_addr    = par_addr_r;
  assign unit_vld    = unit_vld_r;
  // Pixel data arrives in the same cycle as the delayed valid.
  assign unit_input  = unit_vld_r ? pix_din : {DW{1'b0}};
  assign unit_weight = weight_r;
  assign unit_bias   = bias_r;
  assign unit_shift  = shift_r;
  assign out_we      = wr_s;
  assign out_addr    = out_addr_r;
  assign out_data    = wr_s ? unit_dout[7:0] : 8'd0;

endmodule
